// File: rtl/retirement_rat_if.sv
// Retirement RAT port bundle.
// Groups the commit stream, the flush request, the free-list enqueue port and
// the restore stream toward the speculative RAT.
//   master : core side (drives commit/flush, consumes free/restore/busy)
//   slave  : retirement_rat
interface retirement_rat_if #(
  parameter int unsigned ARCH_REGS  = 32,
  parameter int unsigned PREG_WIDTH = 6
);
  localparam int unsigned AW = $clog2(ARCH_REGS);

  logic                  commit_valid_in;
  logic                  commit_regf_we_in;
  logic [AW-1:0]         commit_rd_in;
  logic [PREG_WIDTH-1:0] commit_pd_in;
  logic                  flush_in;

  logic                  free_enqueue_out;
  logic [PREG_WIDTH-1:0] free_wdata_out;
  logic                  restore_valid_out;
  logic [AW-1:0]         restore_arch_out;
  logic [PREG_WIDTH-1:0] restore_pd_out;
  logic                  busy_out;

  modport master (
    output commit_valid_in, commit_regf_we_in, commit_rd_in, commit_pd_in, flush_in,
    input  free_enqueue_out, free_wdata_out, restore_valid_out, restore_arch_out,
           restore_pd_out, busy_out
  );

  modport slave (
    input  commit_valid_in, commit_regf_we_in, commit_rd_in, commit_pd_in, flush_in,
    output free_enqueue_out, free_wdata_out, restore_valid_out, restore_arch_out,
           restore_pd_out, busy_out
  );
endinterface

// File: rtl/retirement_rat.sv
// Retirement register alias table.
// Holds the committed arch->phys mapping. Each register-writing commit updates
// the mapping and returns the superseded preg to the free list one cycle later.
// A flush walks x1..x31 out to the speculative RAT, one entry per cycle.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   rat    : retirement_rat_if.slave (commit, flush, free enqueue, restore, busy)
module retirement_rat #(
  parameter int unsigned ARCH_REGS  = 32,
  parameter int unsigned PHYS_REGS  = 64,
  parameter int unsigned PREG_WIDTH = $clog2(PHYS_REGS)
) (
  input logic             clk,
  input logic             rst_n,
  retirement_rat_if.slave rat
);
  localparam int unsigned   AW      = $clog2(ARCH_REGS);
  localparam logic [AW-1:0] LastIdx = AW'(ARCH_REGS - 1);
  localparam logic [AW-1:0] FirstIdx = AW'(1);

  typedef enum logic [0:0] {StIdle, StWalk} state_e;

  state_e                state_q;
  logic [AW-1:0]         idx_q;
  logic [PREG_WIDTH-1:0] table_q [ARCH_REGS];
  logic                  free_enqueue_q;
  logic [PREG_WIDTH-1:0] free_wdata_q;

  logic commit_fire;
  logic walking;

  // x0 is hardwired in the RAT, so commits to it never touch the table.
  assign commit_fire = rat.commit_valid_in & rat.commit_regf_we_in &
                       (rat.commit_rd_in != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        table_q[i] <= PREG_WIDTH'(i);
      end
      state_q        <= StIdle;
      idx_q          <= FirstIdx;
      free_enqueue_q <= 1'b0;
      free_wdata_q   <= '0;
    end else begin
      free_enqueue_q <= commit_fire;
      if (commit_fire) begin
        // Nonblocking read-before-write: the old mapping is what gets freed.
        free_wdata_q                <= table_q[rat.commit_rd_in];
        table_q[rat.commit_rd_in] <= rat.commit_pd_in;
      end

      // Flush has priority, so a flush on the last walk cycle still restarts.
      if (rat.flush_in) begin
        state_q <= StWalk;
        idx_q   <= FirstIdx;
      end else if (state_q == StWalk) begin
        if (idx_q == LastIdx) begin
          state_q <= StIdle;
          idx_q   <= FirstIdx;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign walking = (state_q == StWalk);

  assign rat.free_enqueue_out  = free_enqueue_q;
  assign rat.free_wdata_out    = free_wdata_q;
  assign rat.busy_out          = walking;
  assign rat.restore_valid_out = walking;
  assign rat.restore_arch_out  = walking ? idx_q : '0;
  // Live table read: commits landing mid-walk are visible to later indices.
  assign rat.restore_pd_out    = walking ? table_q[idx_q] : '0;
endmodule

// File: tb/tb_retirement_rat.sv
module tb_retirement_rat;
  logic clk;
  logic rst_n;

  retirement_rat_if #(.ARCH_REGS(32), .PREG_WIDTH(6)) rif ();

  retirement_rat #(
    .ARCH_REGS (32),
    .PHYS_REGS (64),
    .PREG_WIDTH(6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rat  (rif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_miss;
  int unsigned busy_cnt;

  // Reference model state
  int unsigned mt [32];
  bit          mbusy;
  int unsigned midx;
  int unsigned exp_free [$];

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mt[i] = i;
    mbusy = 1'b0;
    midx  = 1;
    exp_free.delete();
  endtask

  task automatic drive(input bit cv, input bit we, input int unsigned rd,
                       input int unsigned pd, input bit fl);
    rif.commit_valid_in   = cv;
    rif.commit_regf_we_in = we;
    rif.commit_rd_in      = 5'(rd);
    rif.commit_pd_in      = 6'(pd);
    rif.flush_in          = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // Advance one clock: update the model with the inputs presented this cycle,
  // then compare DUT outputs just after the edge.
  task automatic step();
    bit          fire;
    int unsigned rd;
    rd   = rif.commit_rd_in;
    fire = rif.commit_valid_in && rif.commit_regf_we_in && (rd != 0);
    if (fire) begin
      exp_free.push_back(mt[rd]);
      mt[rd] = rif.commit_pd_in;
    end
    if (rif.flush_in) begin
      mbusy = 1'b1;
      midx  = 1;
    end else if (mbusy) begin
      if (midx == 31) begin
        mbusy = 1'b0;
        midx  = 1;
      end else begin
        midx++;
      end
    end

    @(posedge clk);
    #1;
    if (rif.busy_out) busy_cnt++;
    check_eq("free_en", rif.free_enqueue_out, fire);
    if (rif.free_enqueue_out) begin
      if (exp_free.size() == 0) check_eq("free_unexpected", 1, 0);
      else check_eq("free_data", rif.free_wdata_out, exp_free.pop_front());
    end
    check_eq("busy", rif.busy_out, mbusy);
    check_eq("rvalid", rif.restore_valid_out, mbusy);
    if (mbusy) begin
      check_eq("rarch", rif.restore_arch_out, midx);
      check_eq("rpd", rif.restore_pd_out, mt[midx]);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    busy_cnt = 0;
    model_reset();
    idle();
    rst_n = 1'b0;

    // Reset state
    #3;
    check_eq("rst_free_en", rif.free_enqueue_out, 0);
    check_eq("rst_free_data", rif.free_wdata_out, 0);
    check_eq("rst_rvalid", rif.restore_valid_out, 0);
    check_eq("rst_rarch", rif.restore_arch_out, 0);
    check_eq("rst_rpd", rif.restore_pd_out, 0);
    check_eq("rst_busy", rif.busy_out, 0);
    #9 rst_n = 1'b1;

    step();
    step();

    // Flush right after reset: identity restore x1..x31
    drive(1'b0, 1'b0, 0, 0, 1'b1);
    step();
    idle();
    for (int k = 0; k < 31; k++) step();
    check_eq("walk1_done", rif.busy_out, 0);

    // Back-to-back commits to x5
    drive(1'b1, 1'b1, 5, 40, 1'b0);
    step();
    check_eq("free_x5_first", rif.free_wdata_out, 5);
    drive(1'b1, 1'b1, 5, 41, 1'b0);
    step();
    check_eq("free_x5_second", rif.free_wdata_out, 40);

    // x0 commit and regf_we=0 commit free nothing
    drive(1'b1, 1'b1, 0, 50, 1'b0);
    step();
    drive(1'b1, 1'b0, 7, 51, 1'b0);
    step();
    idle();
    step();

    // Commit x31 together with flush
    drive(1'b1, 1'b1, 31, 63, 1'b1);
    step();
    check_eq("free_x31", rif.free_wdata_out, 31);
    idle();
    for (int k = 0; k < 30; k++) step();
    check_eq("last_arch", rif.restore_arch_out, 31);
    check_eq("last_pd", rif.restore_pd_out, 63);
    step();

    // Commit mid-walk, then re-flush after 9 busy cycles
    busy_cnt = 0;
    drive(1'b0, 1'b0, 0, 0, 1'b1);
    step();
    idle();
    step();
    step();
    drive(1'b1, 1'b1, 20, 33, 1'b0);
    step();
    idle();
    for (int k = 0; k < 5; k++) step();
    drive(1'b0, 1'b0, 0, 0, 1'b1);
    step();
    idle();
    for (int k = 0; k < 100 && mbusy; k++) step();
    check_eq("busy_cycles", busy_cnt, 40);

    // Asynchronous reset mid-walk at idx 12
    drive(1'b0, 1'b0, 0, 0, 1'b1);
    step();
    idle();
    for (int k = 0; k < 11; k++) step();
    check_eq("pre_rst_idx", rif.restore_arch_out, 12);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", rif.busy_out, 0);
    check_eq("arst_rvalid", rif.restore_valid_out, 0);
    check_eq("arst_free_en", rif.free_enqueue_out, 0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Table must be identity again
    drive(1'b0, 1'b0, 0, 0, 1'b1);
    step();
    idle();
    for (int k = 0; k < 100 && mbusy; k++) step();
    check_eq("x20_identity", mt[20], 20);

    // Random mix of commits and flushes
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 31),
            $urandom_range(0, 63), 1'($urandom_range(0, 24) == 0));
      step();
    end
    idle();
    for (int k = 0; k < 40; k++) step();
    check_eq("free_pending", exp_free.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/retirement_rat.md
# retirement_rat

Retirement register alias table for the out-of-order core. It holds the committed architectural-to-physical register mapping. On every register-writing commit it updates the mapping and returns the superseded physical register to the physical-register free list through that list's enqueue port. On a pipeline flush it replays the committed mapping into the speculative RAT, one entry per cycle.

## Interface
Parameters:
- ARCH_REGS, 32, number of architectural registers; index 0 is x0.
- PHYS_REGS, 64, number of physical registers.
- PREG_WIDTH, 6, physical register index width, equal to clog2(PHYS_REGS).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- commit_valid_in  in  1  ROB head retires this cycle.
- commit_regf_we_in  in  1  the retiring instruction writes a destination register.
- commit_rd_in  in  5  architectural destination.
- commit_pd_in  in  PREG_WIDTH  physical destination allocated at rename.
- flush_in  in  1  pipeline flush; start the restore walk.
- free_enqueue_out  out  1  enqueue strobe to the free list.
- free_wdata_out  out  PREG_WIDTH  physical register being freed.
- restore_valid_out  out  1  restore entry valid this cycle.
- restore_arch_out  out  5  architectural index being restored.
- restore_pd_out  out  PREG_WIDTH  committed mapping for restore_arch_out.
- busy_out  out  1  restore walk in progress.

## Operation
Table:
- 32 entries of PREG_WIDTH bits.
- Reset value: entry i = i, so x0..x31 map to p0..p31. The free list initially holds p32..p63.

Commit update:
- Fires when commit_valid_in && commit_regf_we_in && commit_rd_in != 0.
- old = table[commit_rd_in], read before the write.
- table[commit_rd_in] <= commit_pd_in.
- Registered outputs: free_enqueue_out <= 1 and free_wdata_out <= old.
- Otherwise free_enqueue_out <= 0 and free_wdata_out holds its last value.

x0 rule:
- A commit with rd == 0, or with regf_we low, changes no table entry and frees nothing.
- Rename never allocates a preg for x0.

FSM:
- IDLE → WALK on flush_in.
- WALK:
  - A counter idx starts at 1.
  - Each cycle drives restore_valid_out=1, restore_arch_out=idx, restore_pd_out=table[idx] (the current table contents, combinational read of the registered table).
  - idx increments each cycle.
  - After idx == 31 the FSM returns to IDLE.
- busy_out = (state == WALK).

Simultaneous events and boundaries:
- Commit and flush in the same cycle (the mispredicted branch retiring): the commit update is applied. The walk starts the next cycle and sees the updated table.
- Commit during WALK is processed normally, including the table write and the free. The walk reads the live table, so an entry committed before its index is reached is restored with the new value.
- flush_in during WALK restarts the walk at idx=1 on the next cycle.
- Back-to-back commits to the same rd: the second commit frees the preg written by the first, because the table was written at the prior edge.
- idx is 5 bits and never wraps. The terminal compare is idx == ARCH_REGS-1.

Reset:
- Asynchronous. rst_n low forces:
  - table to identity;
  - state to IDLE and idx to 1;
  - free_enqueue_out, free_wdata_out, restore_valid_out, restore_arch_out, restore_pd_out, busy_out all to 0.
- Assertion mid-walk aborts the walk immediately.

## Timing
- Commit to free: 1 cycle. A commit at edge T produces free_enqueue_out high during cycle T+1 for exactly one cycle per qualifying commit.
- Sustained throughput is one commit per cycle. The free list never back-pressures, so there is no ready input.
- Flush sampled at edge T:
  - busy_out and restore_valid_out are high from cycle T+1 through T+31 (31 entries, x1..x31).
  - Both are low at T+32.
- x0 is never restored, because the RAT hardwires it.
- Restore outputs are Moore outputs from state/idx plus the table read. They do not depend on the flush_in of the same cycle.

## Test plan
- Reset then idle: all outputs 0 and busy_out 0. A flush immediately after reset restores x1→p1 … x31→p31 on 31 consecutive cycles.
- Commit rd=5, pd=40 → next cycle free_enqueue_out=1, free_wdata_out=5. A second commit rd=5, pd=41 → free_wdata_out=40.
- Commit rd=0, pd=50, and commit rd=7 with regf_we=0 → free_enqueue_out stays 0. A later flush restores x7→p7.
- Commit rd=31, pd=63 in the same cycle as flush → free_wdata_out=31 at T+1. The walk ends with restore_arch_out=31, restore_pd_out=63 at T+31.
- Flush, then commit rd=20, pd=33 at walk cycle 3 → x20 is restored as p33. A re-flush at idx=10 restarts the walk at idx=1; total busy cycles = 9 + 31.
- rst_n low at walk idx=12 → busy_out and restore_valid_out drop without waiting for a clock edge. After release the table is identity.
